// File: rtl/jelly_capacity_splitter.sv
// Capacity splitter: accumulates request size credits and re-issues them as
// bounded ready/valid chunks, holding small remainders until threshold, timeout or flush.
module jelly_capacity_splitter #(
  parameter int CAPACITY_WIDTH      = 32,
  parameter int REQUEST_WIDTH       = CAPACITY_WIDTH,
  parameter int ISSUE_WIDTH         = 16,
  parameter int REQUEST_SIZE_OFFSET = 0,
  parameter int ISSUE_SIZE_OFFSET   = 0,
  parameter int ISSUE_MAX           = 256,
  parameter int THRESHOLD           = 1,
  parameter int TIMEOUT_WIDTH       = 8,
  parameter int INIT_REQUEST        = 0
) (
  input  logic                      reset,
  input  logic                      clk,
  input  logic                      cke,
  input  logic [TIMEOUT_WIDTH-1:0]  param_timeout,
  input  logic                      flush,
  output logic                      busy,
  output logic [CAPACITY_WIDTH-1:0] queued_request,
  input  logic [REQUEST_WIDTH-1:0]  s_request_size,
  input  logic                      s_request_valid,
  output logic [ISSUE_WIDTH-1:0]    m_issue_size,
  output logic                      m_issue_valid,
  input  logic                      m_issue_ready
);

  localparam logic [CAPACITY_WIDTH-1:0] ISSUE_MAX_C  = CAPACITY_WIDTH'(ISSUE_MAX);
  localparam logic [CAPACITY_WIDTH-1:0] THRESHOLD_C  = CAPACITY_WIDTH'(THRESHOLD);
  localparam logic [CAPACITY_WIDTH-1:0] REQ_OFFSET_C = CAPACITY_WIDTH'(REQUEST_SIZE_OFFSET);
  localparam logic [CAPACITY_WIDTH-1:0] ISS_OFFSET_C = CAPACITY_WIDTH'(ISSUE_SIZE_OFFSET);
  localparam logic [CAPACITY_WIDTH-1:0] INIT_C       = CAPACITY_WIDTH'(INIT_REQUEST);

  logic [CAPACITY_WIDTH-1:0] queued_q, queued_d;
  logic                      valid_q, valid_d;
  logic [ISSUE_WIDTH-1:0]    size_q, size_d;
  logic [TIMEOUT_WIDTH-1:0]  timer_q, timer_d;
  logic                      flush_pend_q, flush_pend_d;

  logic                      slot_free;
  logic                      timer_exp;
  logic                      go;
  logic                      drain;
  logic [CAPACITY_WIDTH-1:0] chunk;
  logic [CAPACITY_WIDTH-1:0] queued_left;
  logic [CAPACITY_WIDTH-1:0] req_units;

  always_comb begin
    slot_free   = !valid_q || m_issue_ready;
    timer_exp   = (param_timeout != '0) && (timer_q >= param_timeout);
    go          = slot_free && (queued_q != '0) &&
                  ((queued_q >= THRESHOLD_C) || timer_exp || flush_pend_q || flush);
    chunk       = (queued_q > ISSUE_MAX_C) ? ISSUE_MAX_C : queued_q;
    drain       = go && (chunk == queued_q);
    queued_left = go ? (queued_q - chunk) : queued_q;
    req_units   = CAPACITY_WIDTH'(s_request_size) + REQ_OFFSET_C;

    // Requests land after the issue decision, so they are never chunked on arrival.
    queued_d = s_request_valid ? (queued_left + req_units) : queued_left;

    valid_d = valid_q;
    size_d  = size_q;
    if (go) begin
      valid_d = 1'b1;
      size_d  = ISSUE_WIDTH'(chunk - ISS_OFFSET_C);
    end else if (slot_free) begin
      valid_d = 1'b0;
    end

    timer_d = timer_q;
    if (go || (queued_q == '0)) begin
      timer_d = '0;
    end else if (timer_q != '1) begin
      timer_d = timer_q + TIMEOUT_WIDTH'(1);
    end

    if (drain) begin
      flush_pend_d = 1'b0;
    end else if ((queued_q == '0) && !s_request_valid) begin
      flush_pend_d = 1'b0;
    end else begin
      flush_pend_d = flush_pend_q || flush;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      queued_q     <= INIT_C;
      valid_q      <= 1'b0;
      size_q       <= '0;
      timer_q      <= '0;
      flush_pend_q <= 1'b0;
    end else if (cke) begin
      queued_q     <= queued_d;
      valid_q      <= valid_d;
      size_q       <= size_d;
      timer_q      <= timer_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign queued_request = queued_q;
  assign m_issue_size   = size_q;
  assign m_issue_valid  = valid_q;
  assign busy           = (queued_q != '0) || valid_q;

endmodule

// File: tb/tb_jelly_capacity_splitter.sv
// Scoreboard bench: three splitter configurations, expected issue sizes queued
// at stimulus time and popped on each accepted transfer.
module tb_jelly_capacity_splitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // instance A: defaults, timeout disabled
  logic a_rst = 1'b1, a_cke = 1'b1, a_flush = 1'b0, a_rv = 1'b0, a_ready = 1'b0;
  logic [7:0] a_to = '0;
  logic [31:0] a_rsz = '0, a_q;
  logic [15:0] a_size;
  logic a_valid, a_busy;
  logic [31:0] qa[$];

  jelly_capacity_splitter u_a (
    .reset(a_rst), .clk(clk), .cke(a_cke), .param_timeout(a_to), .flush(a_flush),
    .busy(a_busy), .queued_request(a_q), .s_request_size(a_rsz), .s_request_valid(a_rv),
    .m_issue_size(a_size), .m_issue_valid(a_valid), .m_issue_ready(a_ready)
  );

  // instance B: THRESHOLD=64
  logic b_rst = 1'b1, b_cke = 1'b1, b_flush = 1'b0, b_rv = 1'b0, b_ready = 1'b0;
  logic [7:0] b_to = 8'd10;
  logic [31:0] b_rsz = '0, b_q;
  logic [15:0] b_size;
  logic b_valid, b_busy;
  logic [31:0] qb[$];

  jelly_capacity_splitter #(.THRESHOLD(64)) u_b (
    .reset(b_rst), .clk(clk), .cke(b_cke), .param_timeout(b_to), .flush(b_flush),
    .busy(b_busy), .queued_request(b_q), .s_request_size(b_rsz), .s_request_valid(b_rv),
    .m_issue_size(b_size), .m_issue_valid(b_valid), .m_issue_ready(b_ready)
  );

  // instance C: INIT_REQUEST=5, REQUEST_SIZE_OFFSET=1
  logic c_rst = 1'b1, c_cke = 1'b1, c_flush = 1'b0, c_rv = 1'b0, c_ready = 1'b0;
  logic [7:0] c_to = '0;
  logic [31:0] c_rsz = '0, c_q;
  logic [15:0] c_size;
  logic c_valid, c_busy;
  logic [31:0] qc[$];

  jelly_capacity_splitter #(.INIT_REQUEST(5), .REQUEST_SIZE_OFFSET(1)) u_c (
    .reset(c_rst), .clk(clk), .cke(c_cke), .param_timeout(c_to), .flush(c_flush),
    .busy(c_busy), .queued_request(c_q), .s_request_size(c_rsz), .s_request_valid(c_rv),
    .m_issue_size(c_size), .m_issue_valid(c_valid), .m_issue_ready(c_ready)
  );

  // transfer monitors: a handshake seen here completes on the next rising edge
  always @(negedge clk) begin
    if (!a_rst && a_cke && a_valid && a_ready) begin
      if (qa.size() == 0) chk("a_unexpected_issue", 32'd1, 32'd0);
      else chk("a_issue_size", 32'(a_size), qa.pop_front());
    end
    if (!b_rst && b_cke && b_valid && b_ready) begin
      if (qb.size() == 0) chk("b_unexpected_issue", 32'd1, 32'd0);
      else chk("b_issue_size", 32'(b_size), qb.pop_front());
    end
    if (!c_rst && c_cke && c_valid && c_ready) begin
      if (qc.size() == 0) chk("c_unexpected_issue", 32'd1, 32'd0);
      else chk("c_issue_size", 32'(c_size), qc.pop_front());
    end
  end

  initial begin
    tick(); tick();
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
    chk("a_rst_valid", 32'(a_valid), 32'd0);
    chk("a_rst_size", 32'(a_size), 32'd0);
    chk("a_rst_queued", a_q, 32'd0);
    chk("a_rst_busy", 32'(a_busy), 32'd0);
    chk("c_rst_queued", c_q, 32'd5);
    chk("c_rst_valid", 32'(c_valid), 32'd0);

    // single request, issue on the following edge
    a_ready = 1'b1; a_rsz = 32'd100; a_rv = 1'b1; qa.push_back(32'd100);
    tick(); a_rv = 1'b0;
    chk("t1_queued", a_q, 32'd100);
    chk("t1_valid_lat", 32'(a_valid), 32'd0);
    chk("t1_busy", 32'(a_busy), 32'd1);
    tick();
    chk("t1_valid", 32'(a_valid), 32'd1);
    chk("t1_size", 32'(a_size), 32'd100);
    chk("t1_queued_after", a_q, 32'd0);
    tick();
    chk("t1_valid_drop", 32'(a_valid), 32'd0);
    chk("t1_busy_drop", 32'(a_busy), 32'd0);

    // zero-size request
    a_rsz = 32'd0; a_rv = 1'b1;
    tick(); a_rv = 1'b0;
    chk("zero_queued", a_q, 32'd0);
    chk("zero_valid", 32'(a_valid), 32'd0);

    // chunking 600 -> 256,256,88
    a_rsz = 32'd600; a_rv = 1'b1;
    qa.push_back(32'd256); qa.push_back(32'd256); qa.push_back(32'd88);
    tick(); a_rv = 1'b0;
    chk("t2_queued", a_q, 32'd600);
    tick();
    chk("t2_size0", 32'(a_size), 32'd256);
    chk("t2_queued0", a_q, 32'd344);
    tick();
    chk("t2_queued1", a_q, 32'd88);
    tick();
    chk("t2_size2", 32'(a_size), 32'd88);
    chk("t2_valid2", 32'(a_valid), 32'd1);
    tick();
    chk("t2_valid_end", 32'(a_valid), 32'd0);
    chk("t2_sb_empty", 32'(qa.size()), 32'd0);

    // backpressure: held issue while more requests accumulate
    a_ready = 1'b0; a_rsz = 32'd40; a_rv = 1'b1;
    tick(); a_rv = 1'b0;
    tick();
    chk("t4_valid", 32'(a_valid), 32'd1);
    chk("t4_size", 32'(a_size), 32'd40);
    for (int i = 0; i < 3; i++) begin
      a_rsz = 32'd20; a_rv = 1'b1;
      tick();
      chk("t4_hold_size", 32'(a_size), 32'd40);
      chk("t4_hold_valid", 32'(a_valid), 32'd1);
    end
    a_rv = 1'b0;
    chk("t4_queued", a_q, 32'd60);
    qa.push_back(32'd40); qa.push_back(32'd60);
    a_ready = 1'b1;
    tick();
    chk("t4_next_size", 32'(a_size), 32'd60);
    chk("t4_next_valid", 32'(a_valid), 32'd1);
    chk("t4_queued_after", a_q, 32'd0);
    tick();
    chk("t4_valid_end", 32'(a_valid), 32'd0);

    // clock enable freezes a pending issue and ignores requests
    a_rsz = 32'd30; a_rv = 1'b1;
    tick();
    chk("cke_queued", a_q, 32'd30);
    a_cke = 1'b0; a_rsz = 32'd7;
    repeat (3) tick();
    chk("cke_frozen_q", a_q, 32'd30);
    chk("cke_frozen_v", 32'(a_valid), 32'd0);
    a_rv = 1'b0; a_cke = 1'b1; qa.push_back(32'd30);
    tick();
    chk("cke_resume_v", 32'(a_valid), 32'd1);
    chk("cke_resume_s", 32'(a_size), 32'd30);
    tick();

    // threshold 64 with timeout 10
    b_ready = 1'b1; b_rsz = 32'd10; b_rv = 1'b1;
    tick(); b_rv = 1'b0;
    chk("t3_queued", b_q, 32'd10);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_wait_valid", 32'(b_valid), 32'd0);
    end
    qb.push_back(32'd10);
    tick();
    chk("t3_valid", 32'(b_valid), 32'd1);
    chk("t3_size", 32'(b_size), 32'd10);
    tick();
    chk("t3_valid_end", 32'(b_valid), 32'd0);

    // flush with threshold 64, timeout disabled
    b_to = 8'd0; b_rsz = 32'd30; b_rv = 1'b1;
    tick(); b_rv = 1'b0;
    repeat (3) tick();
    chk("t5_no_issue", 32'(b_valid), 32'd0);
    b_flush = 1'b1; qb.push_back(32'd30);
    tick(); b_flush = 1'b0;
    chk("t5_valid", 32'(b_valid), 32'd1);
    chk("t5_size", 32'(b_size), 32'd30);
    chk("t5_queued", b_q, 32'd0);
    tick();
    chk("t5_valid_end", 32'(b_valid), 32'd0);
    b_flush = 1'b1;
    tick(); b_flush = 1'b0;
    b_rsz = 32'd20; b_rv = 1'b1;
    tick(); b_rv = 1'b0;
    repeat (4) tick();
    chk("t5_empty_flush_noop", 32'(b_valid), 32'd0);
    chk("t5_hold_queued", b_q, 32'd20);
    b_flush = 1'b1; qb.push_back(32'd20);
    tick(); b_flush = 1'b0;
    chk("t5_drain_size", 32'(b_size), 32'd20);
    tick();

    // INIT_REQUEST and reset during an outstanding issue
    c_rst = 1'b0;
    tick();
    chk("t6_init_valid", 32'(c_valid), 32'd1);
    chk("t6_init_size", 32'(c_size), 32'd5);
    c_rst = 1'b1;
    tick();
    chk("t6_rst_valid", 32'(c_valid), 32'd0);
    chk("t6_rst_size", 32'(c_size), 32'd0);
    chk("t6_rst_queued", c_q, 32'd5);
    c_rst = 1'b0; c_ready = 1'b1; qc.push_back(32'd5);
    tick();
    chk("t6_rel_valid", 32'(c_valid), 32'd1);
    chk("t6_rel_size", 32'(c_size), 32'd5);
    c_rsz = 32'd0; c_rv = 1'b1; qc.push_back(32'd1);
    tick(); c_rv = 1'b0;
    chk("t6_off_queued", c_q, 32'd1);
    chk("t6_off_gap", 32'(c_valid), 32'd0);
    tick();
    chk("t6_off_size", 32'(c_size), 32'd1);
    tick();
    chk("t6_valid_end", 32'(c_valid), 32'd0);

    repeat (3) tick();
    chk("a_sb_drained", 32'(qa.size()), 32'd0);
    chk("b_sb_drained", 32'(qb.size()), 32'd0);
    chk("c_sb_drained", 32'(qc.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
